// File: rtl/csr_def.sv
// Shared CSR/CLINT definitions: timer types, CLINT register offsets and a
// byte-lane merge helper used by the timer register file.
package csr_def;

    typedef logic [63:0] mtime_t;
    typedef logic [63:0] mtimecmp_t;

    localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
    localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;
    localparam mtimecmp_t   MTIMECMP_INIT      = '1;

    typedef enum logic [2:0] {
        SEL_MSIP,
        SEL_CMP_LO,
        SEL_CMP_HI,
        SEL_TIME_LO,
        SEL_TIME_HI,
        SEL_NONE
    } reg_sel_e;

    function automatic logic [31:0] merge_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[8*i +: 8] = wstrb[i] ? wdata[8*i +: 8] : old_val[8*i +: 8];
        return res;
    endfunction

endpackage

// File: rtl/clint_timer_if.sv
// Request/response port of the CLINT timer register window.
interface clint_timer_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wstrb;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/clint_tick_gen.sv
// mtime prescaler: tick is high for one cycle every TICK_DIV core clocks
// (constantly high when TICK_DIV is 1).
module clint_tick_gen #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int unsigned      CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CNT_MAX);
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/clint_timer.sv
// CLINT subset for one hart: mtime/mtimecmp/msip behind a request/response
// window, with registered mtip comparison and a one-deep response register.
module clint_timer
    import csr_def::*;
#(
    parameter int unsigned TICK_DIV = 1,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    clint_timer_if.slave bus,
    output logic         mtip,
    output logic         msip,
    output mtime_t       mtime_o
);
    logic        tick;
    logic        accept, wr;
    reg_sel_e    sel;
    logic [31:0] rd_val;

    mtime_t      mtime_q, mtime_d;
    mtimecmp_t   mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic        mtip_q, mtip_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    clint_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    assign bus.req_ready = !resp_valid_q || bus.resp_ready;
    assign accept        = bus.req_valid && bus.req_ready;
    assign wr            = accept && bus.req_we;

    // Exact offset matches; any misaligned or unmapped address faults.
    always_comb begin
        sel = SEL_NONE;
        if (bus.req_addr[1:0] == 2'b00) begin
            if      (bus.req_addr == ADDR_W'(CLINT_MSIP_OFF))             sel = SEL_MSIP;
            else if (bus.req_addr == ADDR_W'(CLINT_MTIMECMP_OFF))         sel = SEL_CMP_LO;
            else if (bus.req_addr == ADDR_W'(CLINT_MTIMECMP_OFF + 16'd4)) sel = SEL_CMP_HI;
            else if (bus.req_addr == ADDR_W'(CLINT_MTIME_OFF))            sel = SEL_TIME_LO;
            else if (bus.req_addr == ADDR_W'(CLINT_MTIME_OFF + 16'd4))    sel = SEL_TIME_HI;
        end
    end

    always_comb begin
        case (sel)
            SEL_MSIP:    rd_val = {31'b0, msip_q};
            SEL_CMP_LO:  rd_val = mtimecmp_q[31:0];
            SEL_CMP_HI:  rd_val = mtimecmp_q[63:32];
            SEL_TIME_LO: rd_val = mtime_q[31:0];
            SEL_TIME_HI: rd_val = mtime_q[63:32];
            default:     rd_val = 32'h0;
        endcase
    end

    always_comb begin
        // A write to either mtime word overrides the tick increment entirely.
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        if (wr && sel == SEL_TIME_LO)
            mtime_d = {mtime_q[63:32], merge_wstrb(mtime_q[31:0], bus.req_wdata, bus.req_wstrb)};
        if (wr && sel == SEL_TIME_HI)
            mtime_d = {merge_wstrb(mtime_q[63:32], bus.req_wdata, bus.req_wstrb), mtime_q[31:0]};

        mtimecmp_d = mtimecmp_q;
        if (wr && sel == SEL_CMP_LO)
            mtimecmp_d[31:0] = merge_wstrb(mtimecmp_q[31:0], bus.req_wdata, bus.req_wstrb);
        if (wr && sel == SEL_CMP_HI)
            mtimecmp_d[63:32] = merge_wstrb(mtimecmp_q[63:32], bus.req_wdata, bus.req_wstrb);

        msip_d = msip_q;
        if (wr && sel == SEL_MSIP && bus.req_wstrb[0])
            msip_d = bus.req_wdata[0];

        mtip_d = (mtime_q >= mtimecmp_q);

        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        if (accept) begin
            resp_valid_d = 1'b1;
            resp_err_d   = (sel == SEL_NONE);
            resp_rdata_d = bus.req_we ? 32'h0 : rd_val;
        end else if (bus.resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q      <= '0;
            mtimecmp_q   <= MTIMECMP_INIT;
            msip_q       <= 1'b0;
            mtip_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            mtime_q      <= mtime_d;
            mtimecmp_q   <= mtimecmp_d;
            msip_q       <= msip_d;
            mtip_q       <= mtip_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign mtip           = mtip_q;
    assign msip           = msip_q;
    assign mtime_o        = mtime_q;
endmodule

// File: tb/tb_clint_timer.sv
// Scoreboard bench for clint_timer: one instance at TICK_DIV=1 for bus and
// interrupt behaviour, a second at TICK_DIV=4 for prescaler behaviour.
module tb_clint_timer;
    import csr_def::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    clint_timer_if #(.ADDR_W(16)) bus ();
    clint_timer_if #(.ADDR_W(16)) bus4 ();

    logic   mtip, msip, mtip4, msip4;
    mtime_t mtime_o, mtime4;

    clint_timer #(.TICK_DIV(1), .ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .mtip(mtip), .msip(msip), .mtime_o(mtime_o)
    );
    clint_timer #(.TICK_DIV(4), .ADDR_W(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4), .mtip(mtip4), .msip(msip4), .mtime_o(mtime4)
    );

    int total = 0;
    int bad   = 0;
    logic [32:0] exp_q[$];   // {err, rdata} per accepted request, in order

    logic        v, e, xe;
    logic [31:0] d, xd;

    // Drive one request, push its expectation, return observed and expected
    // response one edge after acceptance.
    task automatic xfer(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input logic exp_err, input logic [31:0] exp_rd,
                        output logic ov, output logic oe, output logic [31:0] od,
                        output logic oxe, output logic [31:0] oxd);
        int n;
        logic [32:0] x;
        exp_q.push_back({exp_err, exp_rd});
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
        bus.req_wdata = wd;   bus.req_wstrb = ws;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        ov = bus.resp_valid; oe = bus.resp_err; od = bus.resp_rdata;
        x = exp_q.pop_front();
        {oxe, oxd} = x;
    endtask

    task automatic test_reset();
        #12;
        total++; if (mtime_o !== 64'd0) begin bad++; $display("FAIL rst_mtime: got %h required 0", mtime_o); end
        total++; if ({mtip, msip, mtip4, msip4} !== 4'b0) begin bad++; $display("FAIL rst_irq: got %b required 0000", {mtip, msip, mtip4, msip4}); end
        total++; if ({bus.resp_valid, bus.resp_err, bus.resp_rdata} !== 34'd0) begin bad++; $display("FAIL rst_resp: got v=%0b e=%0b d=%h required 0", bus.resp_valid, bus.resp_err, bus.resp_rdata); end
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %0b required 1", bus.req_ready); end
        @(negedge clk); rst_n = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        total++; if (mtime_o !== 64'd10) begin bad++; $display("FAIL idle_mtime: got %0d required 10", mtime_o); end
        total++; if ({mtip, msip} !== 2'b00) begin bad++; $display("FAIL idle_irq: got %b required 00", {mtip, msip}); end
        xfer(1'b0, 16'h4004, 32'h0, 4'h0, 1'b0, 32'hFFFF_FFFF, v, e, d, xe, xd);
        total++; if ({v, e, d} !== {1'b1, xe, xd}) begin bad++; $display("FAIL rd_cmp_hi: got v=%0b e=%0b d=%h required v=1 e=%0b d=%h", v, e, d, xe, xd); end
    endtask

    task automatic test_mtip();
        int n;
        xfer(1'b1, 16'h4004, 32'h0, 4'hF, 1'b0, 32'h0, v, e, d, xe, xd);
        total++; if ({v, e, d} !== {1'b1, xe, xd}) begin bad++; $display("FAIL wr_cmp_hi: got v=%0b e=%0b d=%h required e=%0b d=%h", v, e, d, xe, xd); end
        xfer(1'b1, 16'hBFF8, 32'h0, 4'hF, 1'b0, 32'h0, v, e, d, xe, xd);
        total++; if ({v, e, d} !== {1'b1, xe, xd}) begin bad++; $display("FAIL wr_time_lo: got v=%0b e=%0b d=%h required e=%0b d=%h", v, e, d, xe, xd); end
        xfer(1'b1, 16'h4000, 32'd20, 4'hF, 1'b0, 32'h0, v, e, d, xe, xd);
        total++; if ({v, e, d} !== {1'b1, xe, xd}) begin bad++; $display("FAIL wr_cmp_lo: got v=%0b e=%0b d=%h required e=%0b d=%h", v, e, d, xe, xd); end
        n = 0;
        while (mtime_o !== 64'd20 && n < 100) begin @(posedge clk); #1; n++; end
        total++; if (mtime_o !== 64'd20) begin bad++; $display("FAIL mtime_reach20: got %0d required 20 within 100 cycles", mtime_o); end
        total++; if (mtip !== 1'b0) begin bad++; $display("FAIL mtip_at20: got %0b required 0", mtip); end
        @(posedge clk); #1;
        total++; if (mtip !== 1'b1) begin bad++; $display("FAIL mtip_rise: got %0b required 1", mtip); end
        repeat (5) begin @(posedge clk); #1; end
        total++; if (mtip !== 1'b1) begin bad++; $display("FAIL mtip_hold: got %0b required 1", mtip); end
        xfer(1'b1, 16'h4000, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0, v, e, d, xe, xd);
        total++; if (mtip !== 1'b1) begin bad++; $display("FAIL mtip_lag: got %0b required 1", mtip); end
        @(posedge clk); #1;
        total++; if (mtip !== 1'b0) begin bad++; $display("FAIL mtip_fall: got %0b required 0", mtip); end
    endtask

    task automatic test_carry();
        xfer(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0, v, e, d, xe, xd);
        xfer(1'b1, 16'hBFFC, 32'h0, 4'hF, 1'b0, 32'h0, v, e, d, xe, xd);
        total++; if (mtime_o !== 64'h0_FFFF_FFFF) begin bad++; $display("FAIL carry_pre: got %h required 00000000ffffffff", mtime_o); end
        @(posedge clk); #1;
        total++; if (mtime_o !== 64'h1_0000_0000) begin bad++; $display("FAIL carry_post: got %h required 0000000100000000", mtime_o); end
        xfer(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0, v, e, d, xe, xd);
        xfer(1'b1, 16'hBFFC, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0, v, e, d, xe, xd);
        total++; if (mtime_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL wrap_pre: got %h required all ones", mtime_o); end
        @(posedge clk); #1;
        total++; if (mtime_o !== 64'd0) begin bad++; $display("FAIL wrap_post: got %h required 0", mtime_o); end
    endtask

    task automatic test_msip();
        xfer(1'b1, 16'h0000, 32'hFFFF_FFFF, 4'b0001, 1'b0, 32'h0, v, e, d, xe, xd);
        total++; if (msip !== 1'b1) begin bad++; $display("FAIL msip_set: got %0b required 1", msip); end
        xfer(1'b0, 16'h0000, 32'h0, 4'h0, 1'b0, 32'h1, v, e, d, xe, xd);
        total++; if ({v, e, d} !== {1'b1, xe, xd}) begin bad++; $display("FAIL msip_rd: got v=%0b e=%0b d=%h required e=%0b d=%h", v, e, d, xe, xd); end
        xfer(1'b1, 16'h0000, 32'h0, 4'b0010, 1'b0, 32'h0, v, e, d, xe, xd);
        total++; if (msip !== 1'b1) begin bad++; $display("FAIL msip_lane: got %0b required 1", msip); end
    endtask

    task automatic test_fault();
        xfer(1'b0, 16'h0004, 32'h0, 4'h0, 1'b1, 32'h0, v, e, d, xe, xd);
        total++; if ({v, e, d} !== {1'b1, xe, xd}) begin bad++; $display("FAIL fault_unmapped: got v=%0b e=%0b d=%h required e=%0b d=%h", v, e, d, xe, xd); end
        xfer(1'b1, 16'h4002, 32'h1234_5678, 4'hF, 1'b1, 32'h0, v, e, d, xe, xd);
        total++; if ({v, e, d} !== {1'b1, xe, xd}) begin bad++; $display("FAIL fault_misalign: got v=%0b e=%0b d=%h required e=%0b d=%h", v, e, d, xe, xd); end
        xfer(1'b0, 16'hBFFA, 32'h0, 4'h0, 1'b1, 32'h0, v, e, d, xe, xd);
        total++; if ({v, e, d} !== {1'b1, xe, xd}) begin bad++; $display("FAIL fault_rd_misalign: got v=%0b e=%0b d=%h required e=%0b d=%h", v, e, d, xe, xd); end
        xfer(1'b0, 16'h4000, 32'h0, 4'h0, 1'b0, 32'hFFFF_FFFF, v, e, d, xe, xd);
        total++; if ({v, e, d} !== {1'b1, xe, xd}) begin bad++; $display("FAIL fault_cmp_lo: got v=%0b e=%0b d=%h required e=%0b d=%h", v, e, d, xe, xd); end
        xfer(1'b0, 16'h4004, 32'h0, 4'h0, 1'b0, 32'h0, v, e, d, xe, xd);
        total++; if ({v, e, d} !== {1'b1, xe, xd}) begin bad++; $display("FAIL fault_cmp_hi: got v=%0b e=%0b d=%h required e=%0b d=%h", v, e, d, xe, xd); end
    endtask

    task automatic test_backpressure();
        logic [32:0] x;
        bus.resp_ready = 1'b0;
        exp_q.push_back({1'b0, 32'h0});   // read of mtimecmp high word
        exp_q.push_back({1'b0, 32'h1});   // read of msip
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 16'h4004;
        @(posedge clk); #1;
        bus.req_addr = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready%0d: got %0b required 0", i, bus.req_ready); end
            total++; if ({bus.resp_valid, bus.resp_err, bus.resp_rdata} !== {1'b1, exp_q[0]}) begin bad++; $display("FAIL bp_hold%0d: got v=%0b e=%0b d=%h required v=1 {e,d}=%h", i, bus.resp_valid, bus.resp_err, bus.resp_rdata, exp_q[0]); end
            @(posedge clk); #1;
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %0b required 1", bus.req_ready); end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        void'(exp_q.pop_front());
        x = exp_q.pop_front();
        total++; if ({bus.resp_valid, bus.resp_err, bus.resp_rdata} !== {1'b1, x}) begin bad++; $display("FAIL bp_next: got v=%0b e=%0b d=%h required v=1 {e,d}=%h", bus.resp_valid, bus.resp_err, bus.resp_rdata, x); end
        @(posedge clk); #1;
        total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: got %0b required 0", bus.resp_valid); end
    endtask

    task automatic test_tick_div4();
        int n;
        mtime_t start;
        start = mtime4;
        n = 0;
        while (mtime4 === start && n < 10) begin @(posedge clk); #1; n++; end
        total++; if (mtime4 === start) begin bad++; $display("FAIL div4_tick_seen: got %h unchanged, required a tick within 10 cycles", mtime4); end
        repeat (3) begin @(posedge clk); #1; end
        bus4.req_valid = 1'b1; bus4.req_we = 1'b1; bus4.req_addr = 16'hBFF8;
        bus4.req_wdata = 32'h100; bus4.req_wstrb = 4'hF;
        @(posedge clk); #1;
        bus4.req_valid = 1'b0;
        total++; if ({bus4.resp_valid, bus4.resp_err, bus4.resp_rdata} !== {1'b1, 1'b0, 32'h0}) begin bad++; $display("FAIL div4_resp: got v=%0b e=%0b d=%h required v=1 e=0 d=0", bus4.resp_valid, bus4.resp_err, bus4.resp_rdata); end
        total++; if (mtime4 !== 64'h100) begin bad++; $display("FAIL div4_wr_prio: got %h required 100", mtime4); end
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1;
            total++; if (mtime4 !== 64'h100) begin bad++; $display("FAIL div4_hold%0d: got %h required 100", k, mtime4); end
        end
        @(posedge clk); #1;
        total++; if (mtime4 !== 64'h101) begin bad++; $display("FAIL div4_tick1: got %h required 101", mtime4); end
        repeat (4) begin @(posedge clk); #1; end
        total++; if (mtime4 !== 64'h102) begin bad++; $display("FAIL div4_tick2: got %h required 102", mtime4); end
    endtask

    task automatic test_reset_mid();
        bus.resp_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 16'h4000;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("FAIL mid_pending: got %0b required 1", bus.resp_valid); end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({bus.resp_valid, bus.req_ready} !== 2'b01) begin bad++; $display("FAIL mid_async_resp: got v=%0b rdy=%0b required v=0 rdy=1", bus.resp_valid, bus.req_ready); end
        total++; if ({mtime_o, mtime4} !== 128'd0 || {msip, mtip} !== 2'b00) begin bad++; $display("FAIL mid_async_state: got mtime=%h mtime4=%h msip=%0b mtip=%0b required all 0", mtime_o, mtime4, msip, mtip); end
        bus.resp_ready = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if ({bus.resp_valid, bus.req_ready} !== 2'b01) begin bad++; $display("FAIL mid_after: got v=%0b rdy=%0b required v=0 rdy=1", bus.resp_valid, bus.req_ready); end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 16'h0;
        bus.req_wdata = 32'h0; bus.req_wstrb = 4'h0; bus.resp_ready = 1'b1;
        bus4.req_valid = 1'b0; bus4.req_we = 1'b0; bus4.req_addr = 16'h0;
        bus4.req_wdata = 32'h0; bus4.req_wstrb = 4'h0; bus4.resp_ready = 1'b1;
        test_reset();
        test_mtip();
        test_carry();
        test_msip();
        test_fault();
        test_backpressure();
        test_tick_div4();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000 time units, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
